// File: rtl/lc3b_pkg.sv
// Shared LC-3b decode constants: opcodes, control-store field encodings and the
// control-store ROM used by the DE stage.
package lc3b_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int IDX_W  = 3;
  localparam int CS_W   = 20;

  localparam logic [2:0] RESET_CC = 3'b010;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LDB  = 4'b0010;
  localparam logic [3:0] OP_STB  = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDW  = 4'b0110;
  localparam logic [3:0] OP_STW  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_SHF  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  // Control-store field masks; multi-bit fields list each encoding.
  localparam logic [CS_W-1:0] CS_LD_REG     = 20'h00001;
  localparam logic [CS_W-1:0] CS_LD_CC      = 20'h00002;
  localparam logic [CS_W-1:0] CS_SIZE_WORD  = 20'h00004;
  localparam logic [CS_W-1:0] CS_DCACHE_EN  = 20'h00008;
  localparam logic [CS_W-1:0] CS_DCACHE_RW  = 20'h00010;
  localparam logic [CS_W-1:0] CS_BR_OP      = 20'h00020;
  localparam logic [CS_W-1:0] CS_UNCOND_OP  = 20'h00040;
  localparam logic [CS_W-1:0] CS_TRAP_OP    = 20'h00080;
  localparam logic [CS_W-1:0] CS_ADDR1_BASE = 20'h00100;
  localparam logic [CS_W-1:0] CS_ADDR2_OFF6 = 20'h00200;
  localparam logic [CS_W-1:0] CS_ADDR2_OFF9 = 20'h00400;
  localparam logic [CS_W-1:0] CS_ADDR2_OF11 = 20'h00600;
  localparam logic [CS_W-1:0] CS_LSHF1      = 20'h00800;
  localparam logic [CS_W-1:0] CS_ALUK_AND   = 20'h01000;
  localparam logic [CS_W-1:0] CS_ALUK_XOR   = 20'h02000;
  localparam logic [CS_W-1:0] CS_RES_SHF    = 20'h04000;
  localparam logic [CS_W-1:0] CS_DRV_MEM    = 20'h08000;
  localparam logic [CS_W-1:0] CS_DRV_ADDR   = 20'h10000;
  localparam logic [CS_W-1:0] CS_DRV_NPC    = 20'h18000;

  // Indexed by {opcode, ir[11]}; ir[11] only matters for JSR vs JSRR.
  function automatic logic [CS_W-1:0] cs_rom(input logic [4:0] idx);
    logic [CS_W-1:0] w;
    w = '0;
    case (idx[4:1])
      OP_BR:   w = CS_BR_OP | CS_ADDR2_OFF9 | CS_LSHF1;
      OP_ADD:  w = CS_LD_REG | CS_LD_CC;
      OP_LDB:  w = CS_LD_REG | CS_LD_CC | CS_DCACHE_EN | CS_ADDR1_BASE | CS_ADDR2_OFF6 | CS_DRV_MEM;
      OP_STB:  w = CS_DCACHE_EN | CS_DCACHE_RW | CS_ADDR1_BASE | CS_ADDR2_OFF6;
      OP_JSR:  w = idx[0] ? (CS_LD_REG | CS_UNCOND_OP | CS_ADDR2_OF11 | CS_LSHF1 | CS_DRV_NPC)
                          : (CS_LD_REG | CS_UNCOND_OP | CS_ADDR1_BASE | CS_DRV_NPC);
      OP_AND:  w = CS_LD_REG | CS_LD_CC | CS_ALUK_AND;
      OP_LDW:  w = CS_LD_REG | CS_LD_CC | CS_SIZE_WORD | CS_DCACHE_EN | CS_ADDR1_BASE
                 | CS_ADDR2_OFF6 | CS_LSHF1 | CS_DRV_MEM;
      OP_STW:  w = CS_SIZE_WORD | CS_DCACHE_EN | CS_DCACHE_RW | CS_ADDR1_BASE | CS_ADDR2_OFF6 | CS_LSHF1;
      OP_XOR:  w = CS_LD_REG | CS_LD_CC | CS_ALUK_XOR;
      OP_JMP:  w = CS_UNCOND_OP | CS_ADDR1_BASE;
      OP_SHF:  w = CS_LD_REG | CS_LD_CC | CS_RES_SHF;
      OP_LEA:  w = CS_LD_REG | CS_ADDR2_OFF9 | CS_LSHF1 | CS_DRV_ADDR;
      OP_TRAP: w = CS_LD_REG | CS_TRAP_OP | CS_DRV_NPC;
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// 2-read/1-write register file with synchronous write and write-through reads,
// so a value retiring from SR is visible to DE in the same cycle.
module reg_file_2r1w
  import lc3b_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr_a,
  input  logic [IDX_W-1:0]  i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_mem [NREG];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata_a = (i_we && i_waddr == i_raddr_a) ? i_wdata : r_mem[i_raddr_a];
    o_rdata_b = (i_we && i_waddr == i_raddr_b) ? i_wdata : r_mem[i_raddr_b];
  end

endmodule

// File: rtl/decode_stage.sv
// LC-3b DE stage: register/CC read with SR bypass, control-store decode,
// AGEX/MEM hazard detection and the DE->AGEX pipeline latch.
module decode_stage
  import lc3b_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       de_npc,
  input  logic [15:0]       de_ir,
  input  logic              de_v,
  input  logic              mem_stall,
  input  logic              v_agex_ld_reg,
  input  logic [2:0]        agex_drid_in,
  input  logic              v_agex_ld_cc,
  input  logic              v_mem_ld_reg,
  input  logic [2:0]        mem_drid,
  input  logic              v_mem_ld_cc,
  input  logic              v_sr_ld_reg,
  input  logic [2:0]        sr_drid,
  input  logic [15:0]       sr_data,
  input  logic              v_sr_ld_cc,
  input  logic [2:0]        sr_cc,
  output logic              dep_stall,
  output logic              v_de_br_stall,
  output logic [15:0]       agex_npc,
  output logic [15:0]       agex_ir,
  output logic [15:0]       agex_sr1,
  output logic [15:0]       agex_sr2,
  output logic [2:0]        agex_cc,
  output logic [2:0]        agex_drid,
  output logic [CS_W-1:0]   agex_cs,
  output logic              agex_v
);

  logic [3:0]        w_opcode;
  logic              w_is_store;
  logic [IDX_W-1:0]  w_sr1_idx;
  logic [IDX_W-1:0]  w_sr2_idx;
  logic [IDX_W-1:0]  w_drid;
  logic              w_need_sr1;
  logic              w_need_sr2;
  logic              w_haz_agex;
  logic              w_haz_mem;
  logic              w_haz_cc;
  logic              w_dep_stall;
  logic              w_ld_agex;
  logic [DATA_W-1:0] w_sr1_data;
  logic [DATA_W-1:0] w_sr2_data;
  logic [2:0]        w_cc;

  logic [2:0]        r_cc;
  logic [15:0]       r_agex_npc;
  logic [15:0]       r_agex_ir;
  logic [15:0]       r_agex_sr1;
  logic [15:0]       r_agex_sr2;
  logic [2:0]        r_agex_cc;
  logic [2:0]        r_agex_drid;
  logic [CS_W-1:0]   r_agex_cs;
  logic              r_agex_v;

  reg_file_2r1w u_rf (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_we      (v_sr_ld_reg),
    .i_waddr   (sr_drid),
    .i_wdata   (sr_data),
    .i_raddr_a (w_sr1_idx),
    .i_raddr_b (w_sr2_idx),
    .o_rdata_a (w_sr1_data),
    .o_rdata_b (w_sr2_data)
  );

  always_comb begin
    w_opcode   = de_ir[15:12];
    w_is_store = (w_opcode == OP_STB) || (w_opcode == OP_STW);
    w_sr1_idx  = de_ir[8:6];
    w_sr2_idx  = w_is_store ? de_ir[11:9] : de_ir[2:0];
    w_drid     = ((w_opcode == OP_JSR) || (w_opcode == OP_TRAP)) ? 3'd7 : de_ir[11:9];
    w_need_sr1 = 1'b0;
    case (w_opcode)
      OP_ADD, OP_AND, OP_XOR, OP_SHF, OP_LDB, OP_LDW,
      OP_STB, OP_STW, OP_JMP: w_need_sr1 = 1'b1;
      OP_JSR:                 w_need_sr1 = ~de_ir[11];
      default:                w_need_sr1 = 1'b0;
    endcase
    w_need_sr2 = w_is_store
               | (((w_opcode == OP_ADD) || (w_opcode == OP_AND) || (w_opcode == OP_XOR)) & ~de_ir[5]);
  end

  // SR-stage writers are absent here on purpose: the write-through bypass covers them.
  always_comb begin
    w_haz_agex  = v_agex_ld_reg & ((w_need_sr1 & (w_sr1_idx == agex_drid_in))
                                 | (w_need_sr2 & (w_sr2_idx == agex_drid_in)));
    w_haz_mem   = v_mem_ld_reg & ((w_need_sr1 & (w_sr1_idx == mem_drid))
                                | (w_need_sr2 & (w_sr2_idx == mem_drid)));
    w_haz_cc    = (w_opcode == OP_BR) & (v_agex_ld_cc | v_mem_ld_cc);
    w_dep_stall = de_v & (w_haz_agex | w_haz_mem | w_haz_cc);
    w_ld_agex   = ~mem_stall;
    w_cc        = v_sr_ld_cc ? sr_cc : r_cc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cc <= RESET_CC;
    end else if (v_sr_ld_cc) begin
      r_cc <= sr_cc;
    end
  end

  // A DE hazard still loads the latch, but as a bubble; mem_stall freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_agex_npc  <= '0;
      r_agex_ir   <= '0;
      r_agex_sr1  <= '0;
      r_agex_sr2  <= '0;
      r_agex_cc   <= '0;
      r_agex_drid <= '0;
      r_agex_cs   <= '0;
      r_agex_v    <= 1'b0;
    end else if (w_ld_agex) begin
      r_agex_npc  <= de_npc;
      r_agex_ir   <= de_ir;
      r_agex_sr1  <= w_sr1_data;
      r_agex_sr2  <= w_sr2_data;
      r_agex_cc   <= w_cc;
      r_agex_drid <= w_drid;
      r_agex_cs   <= cs_rom({w_opcode, de_ir[11]});
      r_agex_v    <= de_v & ~w_dep_stall;
    end
  end

  assign dep_stall     = w_dep_stall;
  assign v_de_br_stall = de_v & ((w_opcode == OP_BR) || (w_opcode == OP_JMP)
                               || (w_opcode == OP_JSR) || (w_opcode == OP_TRAP));
  assign agex_npc      = r_agex_npc;
  assign agex_ir       = r_agex_ir;
  assign agex_sr1      = r_agex_sr1;
  assign agex_sr2      = r_agex_sr2;
  assign agex_cc       = r_agex_cc;
  assign agex_drid     = r_agex_drid;
  assign agex_cs       = r_agex_cs;
  assign agex_v        = r_agex_v;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected latch contents are queued when a
// step is driven and popped after the capturing clock edge.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [15:0] de_npc;
  logic [15:0] de_ir;
  logic        de_v;
  logic        mem_stall;
  logic        v_agex_ld_reg;
  logic [2:0]  agex_drid_in;
  logic        v_agex_ld_cc;
  logic        v_mem_ld_reg;
  logic [2:0]  mem_drid;
  logic        v_mem_ld_cc;
  logic        v_sr_ld_reg;
  logic [2:0]  sr_drid;
  logic [15:0] sr_data;
  logic        v_sr_ld_cc;
  logic [2:0]  sr_cc;
  logic        dep_stall;
  logic        v_de_br_stall;
  logic [15:0] agex_npc;
  logic [15:0] agex_ir;
  logic [15:0] agex_sr1;
  logic [15:0] agex_sr2;
  logic [2:0]  agex_cc;
  logic [2:0]  agex_drid;
  logic [19:0] agex_cs;
  logic        agex_v;

  logic [70:0] exp_q[$];
  int n_assert;
  int n_fail;

  decode_stage dut (
    .clk           (clk),
    .rst           (rst),
    .de_npc        (de_npc),
    .de_ir         (de_ir),
    .de_v          (de_v),
    .mem_stall     (mem_stall),
    .v_agex_ld_reg (v_agex_ld_reg),
    .agex_drid_in  (agex_drid_in),
    .v_agex_ld_cc  (v_agex_ld_cc),
    .v_mem_ld_reg  (v_mem_ld_reg),
    .mem_drid      (mem_drid),
    .v_mem_ld_cc   (v_mem_ld_cc),
    .v_sr_ld_reg   (v_sr_ld_reg),
    .sr_drid       (sr_drid),
    .sr_data       (sr_data),
    .v_sr_ld_cc    (v_sr_ld_cc),
    .sr_cc         (sr_cc),
    .dep_stall     (dep_stall),
    .v_de_br_stall (v_de_br_stall),
    .agex_npc      (agex_npc),
    .agex_ir       (agex_ir),
    .agex_sr1      (agex_sr1),
    .agex_sr2      (agex_sr2),
    .agex_cc       (agex_cc),
    .agex_drid     (agex_drid),
    .agex_cs       (agex_cs),
    .agex_v        (agex_v)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [70:0] lat(input logic v, input logic [15:0] npc, input logic [15:0] ir,
                                      input logic [15:0] sr1, input logic [15:0] sr2,
                                      input logic [2:0] cc, input logic [2:0] drid);
    return {v, npc, ir, sr1, sr2, cc, drid};
  endfunction

  task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [70:0] e);
    exp_q.push_back(e);
  endtask

  // Advance one edge and compare the latch against the oldest queued expectation.
  task automatic tick(input string tag);
    logic [70:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s: no expected entry queued", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, lat(agex_v, agex_npc, agex_ir, agex_sr1, agex_sr2, agex_cc, agex_drid), e);
    end
  endtask

  task automatic drive_de(input logic v, input logic [15:0] npc, input logic [15:0] ir);
    de_v   = v;
    de_npc = npc;
    de_ir  = ir;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    drive_de(1'b0, 16'h0, 16'h0);
    mem_stall = 0; v_agex_ld_reg = 0; agex_drid_in = 0; v_agex_ld_cc = 0;
    v_mem_ld_reg = 0; mem_drid = 0; v_mem_ld_cc = 0;
    v_sr_ld_reg = 0; sr_drid = 0; sr_data = 0; v_sr_ld_cc = 0; sr_cc = 0;

    // Reset
    push(lat(0, 16'h0, 16'h0, 16'h0, 16'h0, 3'b000, 3'd0));
    tick("reset_latch");
    chk("reset_cs", 71'(agex_cs), 71'(20'h0));

    // ADD R1,R1,#1 right after reset
    rst = 1'b0;
    drive_de(1'b1, 16'h3002, 16'h1261);
    #1;
    chk("add_dep_stall", 71'(dep_stall), 71'(1'b0));
    chk("add_br_stall", 71'(v_de_br_stall), 71'(1'b0));
    push(lat(1, 16'h3002, 16'h1261, 16'h0, 16'h0, 3'b010, 3'd1));
    tick("add_imm");
    chk("add_cs", 71'(agex_cs), 71'(20'h00003));

    // Write-through: SR writes R2 while DE reads it
    drive_de(1'b1, 16'h3004, 16'h1680);
    v_sr_ld_reg = 1; sr_drid = 3'd2; sr_data = 16'hBEEF;
    #1;
    chk("wt_dep_stall", 71'(dep_stall), 71'(1'b0));
    push(lat(1, 16'h3004, 16'h1680, 16'hBEEF, 16'h0, 3'b010, 3'd3));
    tick("wt_bypass");
    v_sr_ld_reg = 0;
    drive_de(1'b1, 16'h3006, 16'h1680);
    push(lat(1, 16'h3006, 16'h1680, 16'hBEEF, 16'h0, 3'b010, 3'd3));
    tick("rf_written");

    // AGEX register hazard, then cleared by a different destination
    drive_de(1'b1, 16'h3008, 16'h14C3);
    v_agex_ld_reg = 1; agex_drid_in = 3'd3;
    #1;
    chk("agex_haz_stall", 71'(dep_stall), 71'(1'b1));
    push(lat(0, 16'h3008, 16'h14C3, 16'h0, 16'h0, 3'b010, 3'd2));
    tick("agex_haz_bubble");
    agex_drid_in = 3'd4;
    #1;
    chk("agex_clear_stall", 71'(dep_stall), 71'(1'b0));
    push(lat(1, 16'h3008, 16'h14C3, 16'h0, 16'h0, 3'b010, 3'd2));
    tick("agex_clear");

    // MEM register hazard
    v_agex_ld_reg = 0; v_mem_ld_reg = 1; mem_drid = 3'd3;
    #1;
    chk("mem_haz_stall", 71'(dep_stall), 71'(1'b1));
    push(lat(0, 16'h3008, 16'h14C3, 16'h0, 16'h0, 3'b010, 3'd2));
    tick("mem_haz_bubble");

    // Immediate form: ir[2:0] matches but SR2 is not a source
    drive_de(1'b1, 16'h300A, 16'h1523);
    #1;
    chk("imm_no_stall", 71'(dep_stall), 71'(1'b0));
    push(lat(1, 16'h300A, 16'h1523, 16'h0, 16'h0, 3'b010, 3'd2));
    tick("imm_no_haz");

    // SR-stage writer of a source never stalls; both ports bypass
    drive_de(1'b1, 16'h300C, 16'h14C3);
    mem_drid = 3'd6; v_sr_ld_reg = 1; sr_drid = 3'd3; sr_data = 16'h5555;
    #1;
    chk("sr_no_stall", 71'(dep_stall), 71'(1'b0));
    push(lat(1, 16'h300C, 16'h14C3, 16'h5555, 16'h5555, 3'b010, 3'd2));
    tick("sr_bypass_both");
    v_sr_ld_reg = 0; v_mem_ld_reg = 0;

    // BRz with MEM then AGEX CC writers in flight
    drive_de(1'b1, 16'h3010, 16'h0402);
    v_mem_ld_cc = 1;
    #1;
    chk("br_mem_cc_stall", 71'(dep_stall), 71'(1'b1));
    chk("br_br_stall", 71'(v_de_br_stall), 71'(1'b1));
    push(lat(0, 16'h3010, 16'h0402, 16'h0, 16'hBEEF, 3'b010, 3'd2));
    tick("br_cc_bubble");
    v_mem_ld_cc = 0; v_agex_ld_cc = 1;
    #1;
    chk("br_agex_cc_stall", 71'(dep_stall), 71'(1'b1));
    push(lat(0, 16'h3010, 16'h0402, 16'h0, 16'hBEEF, 3'b010, 3'd2));
    tick("br_agex_bubble");
    v_agex_ld_cc = 0; v_sr_ld_cc = 1; sr_cc = 3'b100;
    #1;
    chk("br_sr_cc_no_stall", 71'(dep_stall), 71'(1'b0));
    push(lat(1, 16'h3010, 16'h0402, 16'h0, 16'hBEEF, 3'b100, 3'd2));
    tick("cc_bypass");
    v_sr_ld_cc = 0;

    // Non-branch ignores CC writers; CC register now holds N
    drive_de(1'b1, 16'h3012, 16'h1261);
    v_agex_ld_cc = 1;
    #1;
    chk("add_cc_no_stall", 71'(dep_stall), 71'(1'b0));
    push(lat(1, 16'h3012, 16'h1261, 16'h0, 16'h0, 3'b100, 3'd1));
    tick("cc_registered");
    v_agex_ld_cc = 0;

    // JSR / JSRR / TRAP link to R7
    drive_de(1'b1, 16'h3014, 16'h4802);
    #1;
    chk("jsr_br_stall", 71'(v_de_br_stall), 71'(1'b1));
    push(lat(1, 16'h3014, 16'h4802, 16'h0, 16'hBEEF, 3'b100, 3'd7));
    tick("jsr_drid");
    drive_de(1'b1, 16'h3016, 16'h4140);
    v_agex_ld_reg = 1; agex_drid_in = 3'd5;
    #1;
    chk("jsrr_haz_stall", 71'(dep_stall), 71'(1'b1));
    push(lat(0, 16'h3016, 16'h4140, 16'h0, 16'h0, 3'b100, 3'd7));
    tick("jsrr_bubble");
    v_agex_ld_reg = 0;
    drive_de(1'b1, 16'h3018, 16'hF025);
    #1;
    chk("trap_br_stall", 71'(v_de_br_stall), 71'(1'b1));
    push(lat(1, 16'h3018, 16'hF025, 16'h0, 16'h0, 3'b100, 3'd7));
    tick("trap_drid");

    // Undefined opcode decodes to an all-zero control word
    drive_de(1'b1, 16'h301A, 16'hA000);
    push(lat(1, 16'h301A, 16'hA000, 16'h0, 16'h0, 3'b100, 3'd0));
    tick("undef_latch");
    chk("undef_cs", 71'(agex_cs), 71'(20'h0));

    // mem_stall holds the latch for 3 cycles, including with a DE hazard
    drive_de(1'b1, 16'h301C, 16'h1680);
    push(lat(1, 16'h301C, 16'h1680, 16'hBEEF, 16'h0, 3'b100, 3'd3));
    tick("pre_hold");
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive_de(1'b1, 16'h3020 + 16'(2 * i), 16'h14C3 + 16'(i));
      v_agex_ld_reg = (i == 1); agex_drid_in = 3'd3;
      push(lat(1, 16'h301C, 16'h1680, 16'hBEEF, 16'h0, 3'b100, 3'd3));
      tick("mem_stall_hold");
    end
    drive_de(1'b1, 16'h3026, 16'h14C3);
    v_agex_ld_reg = 1; rst = 1;
    #1;
    chk("rst_dep_comb", 71'(dep_stall), 71'(1'b1));
    push(lat(0, 16'h0, 16'h0, 16'h0, 16'h0, 3'b000, 3'd0));
    tick("rst_in_hold");
    rst = 0; mem_stall = 0; v_agex_ld_reg = 0;

    // de_v=0: no stalls, bubble; R5 written meanwhile, R2 back to 0 after reset
    drive_de(1'b0, 16'h3028, 16'h0402);
    v_mem_ld_cc = 1; v_sr_ld_reg = 1; sr_drid = 3'd5; sr_data = 16'h1234;
    #1;
    chk("dev0_dep_stall", 71'(dep_stall), 71'(1'b0));
    chk("dev0_br_stall", 71'(v_de_br_stall), 71'(1'b0));
    push(lat(0, 16'h3028, 16'h0402, 16'h0, 16'h0, 3'b010, 3'd2));
    tick("dev0_bubble");
    v_mem_ld_cc = 0; v_sr_ld_reg = 0;

    // STW R5,R1,#0 reads the store data through SR2 = ir[11:9]
    drive_de(1'b1, 16'h302A, 16'h7A40);
    push(lat(1, 16'h302A, 16'h7A40, 16'h0, 16'h1234, 3'b010, 3'd5));
    tick("stw_sr2");
    v_mem_ld_reg = 1; mem_drid = 3'd5;
    #1;
    chk("stw_haz_stall", 71'(dep_stall), 71'(1'b1));
    push(lat(0, 16'h302A, 16'h7A40, 16'h0, 16'h1234, 3'b010, 3'd5));
    tick("stw_bubble");
    v_mem_ld_reg = 0;

    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
